sram_controller: RTL and testbench

- Responder for the memory-stage request interface: accepts one 32-bit read or write per request from the MEM stage and services it on an external 16-bit asynchronous SRAM as two halfword accesses.
- Holds `ready` low while a request is in flight, so the pipeline freezes on `~ready`.
- Sits between the MEM stage and the SRAM pins.
- The tristate data pad is outside this block; this block drives separate `sram_dq_out`/`sram_dq_oe` and reads `sram_dq_in`.

---
 rtl/sram_controller.sv | 180 ++++++++++++++++++
 tb/tb_sram_controller.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/sram_controller.sv
// sram_controller
//   Services 32-bit load/store requests from the MEM stage on a 16-bit
//   asynchronous SRAM as two halfword accesses (low half, then high half).
//   The pipeline stalls while ready is low.
//
// Ports:
//   clk, rst          clock (rising edge), asynchronous active-low reset
//   wr_en, rd_en      request strobes, held until ready (write wins if both)
//   address           byte address of the request
//   write_data        store data
//   read_data         load data, valid while ready is high in the DONE cycle
//   ready             request complete / nothing pending
//   sram_addr         halfword address on the pins
//   sram_dq_out/_oe   write data and output enable for the external pad
//   sram_dq_in        read data from the external pad
//   sram_we_n/_oe_n   active-low write / output enables
//   sram_ce_n/_ub_n/_lb_n  permanently asserted
module sram_controller #(
    parameter logic [31:0] BASE_ADDR     = 32'd1024,
    parameter int          ACCESS_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en,
    input  logic        rd_en,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        ready,
    output logic [17:0] sram_addr,
    output logic [15:0] sram_dq_out,
    output logic        sram_dq_oe,
    input  logic [15:0] sram_dq_in,
    output logic        sram_we_n,
    output logic        sram_oe_n,
    output logic        sram_ce_n,
    output logic        sram_ub_n,
    output logic        sram_lb_n
);

    localparam int CNT_W = (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACCESS_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             is_wr_q, is_wr_d;
    logic [16:0]      word_q, word_d;
    logic [15:0]      wdata_hi_q, wdata_hi_d;
    logic [31:0]      read_data_q, read_data_d;
    logic [17:0]      sram_addr_q, sram_addr_d;
    logic [15:0]      dq_out_q, dq_out_d;
    logic             dq_oe_q, dq_oe_d;
    logic             we_n_q, we_n_d;
    logic             oe_n_q, oe_n_d;

    // Only offset bits [18:2] select the word, so the subtraction needs just
    // the low 19 bits; the rest of the address is intentionally ignored.
    logic [18:0] offset;
    logic [16:0] req_word;
    logic        last_beat;
    logic        unused_bits;

    assign offset      = address[18:0] - BASE_ADDR[18:0];
    assign req_word    = offset[18:2];
    assign unused_bits = ^{address[31:19], offset[1:0]};
    assign last_beat   = (cnt_q == CNT_LAST);

    assign ready       = ~(rd_en | wr_en) | (state_q == DONE);
    assign read_data   = read_data_q;
    assign sram_addr   = sram_addr_q;
    assign sram_dq_out = dq_out_q;
    assign sram_dq_oe  = dq_oe_q;
    assign sram_we_n   = we_n_q;
    assign sram_oe_n   = oe_n_q;
    assign sram_ce_n   = 1'b0;
    assign sram_ub_n   = 1'b0;
    assign sram_lb_n   = 1'b0;

    // Pin values are computed one state ahead so they are registered and
    // already valid in the first cycle of each halfword access.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        is_wr_d     = is_wr_q;
        word_d      = word_q;
        wdata_hi_d  = wdata_hi_q;
        read_data_d = read_data_q;
        sram_addr_d = sram_addr_q;
        dq_out_d    = dq_out_q;
        dq_oe_d     = dq_oe_q;
        we_n_d      = we_n_q;
        oe_n_d      = oe_n_q;
        case (state_q)
            IDLE: begin
                if (wr_en | rd_en) begin
                    state_d     = LO;
                    cnt_d       = '0;
                    is_wr_d     = wr_en;
                    word_d      = req_word;
                    wdata_hi_d  = write_data[31:16];
                    sram_addr_d = {req_word, 1'b0};
                    if (wr_en) begin
                        dq_out_d = write_data[15:0];
                        dq_oe_d  = 1'b1;
                        we_n_d   = 1'b0;
                        oe_n_d   = 1'b1;
                    end else begin
                        dq_oe_d  = 1'b0;
                        we_n_d   = 1'b1;
                        oe_n_d   = 1'b0;
                    end
                end
            end
            LO: begin
                if (last_beat) begin
                    state_d     = HI;
                    cnt_d       = '0;
                    sram_addr_d = {word_q, 1'b1};
                    if (is_wr_q) begin
                        dq_out_d = wdata_hi_q;
                    end else begin
                        read_data_d[15:0] = sram_dq_in;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            HI: begin
                if (last_beat) begin
                    state_d = DONE;
                    cnt_d   = '0;
                    dq_oe_d = 1'b0;
                    we_n_d  = 1'b1;
                    oe_n_d  = 1'b1;
                    if (!is_wr_q) begin
                        read_data_d[31:16] = sram_dq_in;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            is_wr_q     <= 1'b0;
            read_data_q <= '0;
            sram_addr_q <= '0;
            dq_out_q    <= '0;
            dq_oe_q     <= 1'b0;
            we_n_q      <= 1'b1;
            oe_n_q      <= 1'b1;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            is_wr_q     <= is_wr_d;
            read_data_q <= read_data_d;
            sram_addr_q <= sram_addr_d;
            dq_out_q    <= dq_out_d;
            dq_oe_q     <= dq_oe_d;
            we_n_q      <= we_n_d;
            oe_n_q      <= oe_n_d;
        end
    end

    // Latched request data; only consumed after a request has been accepted.
    always_ff @(posedge clk) begin
        word_q     <= word_d;
        wdata_hi_q <= wdata_hi_d;
    end

endmodule

// File: tb/tb_sram_controller.sv
module tb_sram_controller;

    localparam int A = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    int          n_tests = 0;
    int          n_fail  = 0;

    // DUT 0: default timing
    logic        wr_en = 1'b0, rd_en = 1'b0;
    logic [31:0] address = '0, write_data = '0;
    logic [31:0] read_data;
    logic        ready;
    logic [17:0] sram_addr;
    logic [15:0] sram_dq_out, sram_dq_in;
    logic        sram_dq_oe, sram_we_n, sram_oe_n, sram_ce_n, sram_ub_n, sram_lb_n;

    // DUT 1: single-cycle accesses
    logic        wr_en1 = 1'b0, rd_en1 = 1'b0;
    logic [31:0] address1 = '0, write_data1 = '0;
    logic [31:0] read_data1;
    logic        ready1;
    logic [17:0] sram_addr1;
    logic [15:0] sram_dq_out1, sram_dq_in1;
    logic        sram_dq_oe1, sram_we_n1, sram_oe_n1, sram_ce_n1, sram_ub_n1, sram_lb_n1;

    always #5 clk = ~clk;

    sram_controller #(.BASE_ADDR(32'd1024), .ACCESS_CYCLES(A)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .rd_en(rd_en),
        .address(address), .write_data(write_data),
        .read_data(read_data), .ready(ready),
        .sram_addr(sram_addr), .sram_dq_out(sram_dq_out), .sram_dq_oe(sram_dq_oe),
        .sram_dq_in(sram_dq_in), .sram_we_n(sram_we_n), .sram_oe_n(sram_oe_n),
        .sram_ce_n(sram_ce_n), .sram_ub_n(sram_ub_n), .sram_lb_n(sram_lb_n)
    );

    sram_controller #(.BASE_ADDR(32'd1024), .ACCESS_CYCLES(1)) dut1 (
        .clk(clk), .rst(rst), .wr_en(wr_en1), .rd_en(rd_en1),
        .address(address1), .write_data(write_data1),
        .read_data(read_data1), .ready(ready1),
        .sram_addr(sram_addr1), .sram_dq_out(sram_dq_out1), .sram_dq_oe(sram_dq_oe1),
        .sram_dq_in(sram_dq_in1), .sram_we_n(sram_we_n1), .sram_oe_n(sram_oe_n1),
        .sram_ce_n(sram_ce_n1), .sram_ub_n(sram_ub_n1), .sram_lb_n(sram_lb_n1)
    );

    // Contents of never-written SRAM locations
    function automatic logic [15:0] pat(input logic [17:0] a);
        return {a[7:0], a[15:8]} ^ {14'h0, a[17:16]} ^ 16'hC3A5;
    endfunction

    // SRAM device models on the pins
    logic [15:0] sram_mem [0:262143];
    bit          sram_wr  [0:262143];

    always @(posedge clk) begin
        if (!sram_we_n && sram_dq_oe) begin
            sram_mem[sram_addr] <= sram_dq_out;
            sram_wr[sram_addr]  <= 1'b1;
        end
    end

    always_comb begin
        sram_dq_in = 16'h0;
        if (!sram_oe_n) sram_dq_in = sram_wr[sram_addr] ? sram_mem[sram_addr] : pat(sram_addr);
    end

    always_comb begin
        sram_dq_in1 = 16'h0;
        if (!sram_oe_n1) sram_dq_in1 = pat(sram_addr1);
    end

    // Reference model: halfword-addressed memory image and last load result
    logic [15:0] ref_mem [logic [17:0]];
    logic [31:0] last_rd = '0;

    function automatic logic [15:0] ref_half(input logic [17:0] a);
        if (ref_mem.exists(a)) return ref_mem[a];
        return pat(a);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One full transaction on DUT 0, starting in an IDLE cycle.
    task automatic txn(input bit wr, input bit rd, input logic [31:0] addr,
                       input logic [31:0] wd, input bit hold);
        logic [31:0] off;
        logic [17:0] lo, hi;
        bit          is_wr;
        off   = (addr - 32'd1024) % 32'h80000;
        lo    = 18'(off / 4 * 2);
        hi    = lo + 18'd1;
        is_wr = wr;
        @(negedge clk);
        wr_en = wr; rd_en = rd; address = addr; write_data = wd;
        #1;
        chk("ready_at_request", 32'(ready), 32'd0);
        for (int k = 1; k <= 2 * A; k++) begin
            @(posedge clk); #1;
            chk("sram_addr", 32'(sram_addr), 32'(k <= A ? lo : hi));
            chk("we_n", 32'(sram_we_n), 32'(!is_wr));
            chk("oe_n", 32'(sram_oe_n), 32'(is_wr));
            chk("dq_oe", 32'(sram_dq_oe), 32'(is_wr));
            if (is_wr) chk("dq_out", 32'(sram_dq_out), 32'(k <= A ? wd[15:0] : wd[31:16]));
            chk("ready_busy", 32'(ready), 32'd0);
        end
        @(posedge clk); #1;
        if (is_wr) begin
            ref_mem[lo] = wd[15:0];
            ref_mem[hi] = wd[31:16];
        end else begin
            last_rd = {ref_half(hi), ref_half(lo)};
        end
        chk("ready_done", 32'(ready), 32'd1);
        chk("we_n_done", 32'(sram_we_n), 32'd1);
        chk("oe_n_done", 32'(sram_oe_n), 32'd1);
        chk("dq_oe_done", 32'(sram_dq_oe), 32'd0);
        chk("read_data", read_data, last_rd);
        if (hold) begin
            @(posedge clk); #1;
            chk("ready_after_done_held", 32'(ready), 32'd0);
        end else begin
            wr_en = 1'b0; rd_en = 1'b0;
            @(posedge clk); #1;
            chk("ready_after_done", 32'(ready), 32'd1);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a, d;
        int          op;
        logic [31:0] wd_rst;

        // Reset state
        #12;
        chk("rst_read_data", read_data, 32'd0);
        chk("rst_sram_addr", 32'(sram_addr), 32'd0);
        chk("rst_dq_out", 32'(sram_dq_out), 32'd0);
        chk("rst_dq_oe", 32'(sram_dq_oe), 32'd0);
        chk("rst_we_n", 32'(sram_we_n), 32'd1);
        chk("rst_oe_n", 32'(sram_oe_n), 32'd1);
        chk("rst_ready", 32'(ready), 32'd1);
        chk("tie_ce_ub_lb", {29'd0, sram_ce_n, sram_ub_n, sram_lb_n}, 32'd0);
        @(negedge clk); rst = 1'b1;

        // Idle
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            chk("idle_ready", 32'(ready), 32'd1);
            chk("idle_pins", {29'd0, sram_we_n, sram_oe_n, sram_dq_oe}, 32'b110);
        end

        // Write then read back
        txn(1'b1, 1'b0, 32'd1028, 32'hDEADBEEF, 1'b0);
        txn(1'b0, 1'b1, 32'd1028, 32'h0, 1'b0);
        chk("readback_1028", read_data, 32'hDEADBEEF);

        // Back-to-back reads held continuously
        txn(1'b0, 1'b1, 32'd1024, 32'h0, 1'b1);
        txn(1'b0, 1'b1, 32'd2048, 32'h0, 1'b0);

        // Priority: both strobes high performs a write
        txn(1'b1, 1'b1, 32'd1040, 32'h12345678, 1'b0);
        txn(1'b0, 1'b1, 32'd1040, 32'h0, 1'b0);
        chk("priority_readback", read_data, 32'h12345678);

        // Reset during the high half of a write
        wd_rst = 32'hCAFEF00D;
        @(negedge clk);
        wr_en = 1'b1; address = 32'd1100; write_data = wd_rst;
        repeat (A + 1) @(posedge clk);
        #1;
        chk("pre_rst_we_n", 32'(sram_we_n), 32'd0);
        chk("pre_rst_addr_hi", 32'(sram_addr), 32'd39);
        rst = 1'b0;
        #1;
        last_rd = '0;
        chk("midrst_read_data", read_data, 32'd0);
        chk("midrst_sram_addr", 32'(sram_addr), 32'd0);
        chk("midrst_dq_out", 32'(sram_dq_out), 32'd0);
        chk("midrst_pins", {29'd0, sram_we_n, sram_oe_n, sram_dq_oe}, 32'b110);
        wr_en = 1'b0;
        @(negedge clk); rst = 1'b1;
        txn(1'b0, 1'b1, 32'd1200, 32'h0, 1'b0);

        // Randomized traffic
        for (int i = 0; i < 40; i++) begin
            a  = 32'd2048 + 32'($urandom_range(0, 1023));
            if ($urandom_range(0, 3) == 0) a[31:19] = 13'($urandom);
            d  = $urandom;
            op = $urandom_range(0, 2);
            txn(op != 1, op != 0, a, d, (i != 39) && ($urandom_range(0, 1) == 1));
        end

        // Single-cycle access instance
        @(negedge clk);
        rd_en1 = 1'b1; address1 = 32'd1032;
        #1;
        chk("a1_ready_req", 32'(ready1), 32'd0);
        @(posedge clk); #1;
        chk("a1_addr_lo", 32'(sram_addr1), 32'd4);
        chk("a1_oe_n_lo", 32'(sram_oe_n1), 32'd0);
        chk("a1_ready_lo", 32'(ready1), 32'd0);
        @(posedge clk); #1;
        chk("a1_addr_hi", 32'(sram_addr1), 32'd5);
        chk("a1_ready_hi", 32'(ready1), 32'd0);
        @(posedge clk); #1;
        chk("a1_ready_done", 32'(ready1), 32'd1);
        chk("a1_read_data", read_data1, {pat(18'd5), pat(18'd4)});
        rd_en1 = 1'b0;
        @(posedge clk); #1;
        chk("a1_ready_idle", 32'(ready1), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
